// File: rtl/sym_timing_nco.sv
// Symbol-timing NCO: fractional phase accumulator that wraps at the oversampling factor and emits a symbol strobe.
// Optional slip statistics (early/late period counters) are enabled by defining SYM_NCO_SLIP_STATS_EN.
module sym_timing_nco #(
  parameter int unsigned OSF_MAX  = 32,
  parameter int unsigned INT_W    = 6,
  parameter int unsigned FRAC_W   = 26,
  parameter int unsigned CTRL_W   = 18,
  parameter int unsigned MAX_CORR = 2047
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [INT_W-1:0]  osf_i,
  input  logic              cfg_load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              ctrl_valid_i,
  input  logic              hold_i,
  output logic              sym_valid_o,
  output logic [INT_W-1:0]  phase_int_o,
  output logic [FRAC_W-1:0] mu_o,
  output logic              phase_val_o,
  output logic              ctrl_sat_o,
  output logic              cfg_err_o,
  output logic [15:0]       early_cnt_o,
  output logic [15:0]       late_cnt_o
);

  localparam int unsigned PHI_W   = INT_W + FRAC_W;
  localparam int unsigned SUM_W   = PHI_W + 1;
  localparam int unsigned OSF_RST = (OSF_MAX < 20) ? OSF_MAX : 20;
  localparam int unsigned CORR_SH = FRAC_W - 12;

  localparam logic [SUM_W-1:0]         ONE_SAMP = SUM_W'(1) << FRAC_W;
  localparam logic signed [CTRL_W-1:0] CORR_POS = CTRL_W'(MAX_CORR);
  localparam logic signed [CTRL_W-1:0] CORR_NEG = -CORR_POS;

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [PHI_W-1:0]          phi_q;
  logic [INT_W-1:0]          osf_q;
  logic signed [CTRL_W-1:0]  ctrl_q;

  logic                      cfg_ok, cfg_bad, cap_en;
  logic signed [CTRL_W-1:0]  ctrl_s, ctrl_clamp;
  logic                      ctrl_clip;
  logic [SUM_W-1:0]          corr_ext, step, phi_sum, wrap_thr;
  logic                      wrap;
  logic [PHI_W-1:0]          phi_nxt;

  assign cfg_ok  = cfg_load_i && (osf_i >= INT_W'(2)) && (osf_i <= INT_W'(OSF_MAX));
  assign cfg_bad = cfg_load_i && !cfg_ok;
  assign cap_en  = ctrl_valid_i && (state_q != HOLD);

  // Clamp the incoming correction to +/-MAX_CORR
  always_comb begin
    ctrl_s     = $signed(ctrl_i);
    ctrl_clamp = ctrl_s;
    ctrl_clip  = 1'b0;
    if (ctrl_s > CORR_POS) begin
      ctrl_clamp = CORR_POS;
      ctrl_clip  = 1'b1;
    end else if (ctrl_s < CORR_NEG) begin
      ctrl_clamp = CORR_NEG;
      ctrl_clip  = 1'b1;
    end
  end

  // Phase step and single-wrap accumulator update; true sum is never negative so modular add is exact
  always_comb begin
    corr_ext = {{(SUM_W-CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q};
    step     = ONE_SAMP;
    if (state_q != IDLE) begin
      step = ONE_SAMP + (corr_ext << CORR_SH);
    end
    phi_sum  = {1'b0, phi_q} + step;
    wrap_thr = {1'b0, osf_q, {FRAC_W{1'b0}}};
    wrap     = (phi_sum >= wrap_thr);
    phi_nxt  = wrap ? PHI_W'(phi_sum - wrap_thr) : PHI_W'(phi_sum);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ctrl_valid_i) state_d = TRACK;
        TRACK:   if (hold_i)       state_d = HOLD;
        HOLD:    if (!hold_i)      state_d = TRACK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers; an accepted load wins over capture and wrap on the same edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phi_q       <= '0;
      osf_q       <= INT_W'(OSF_RST);
      ctrl_q      <= '0;
      sym_valid_o <= 1'b0;
      ctrl_sat_o  <= 1'b0;
      cfg_err_o   <= 1'b0;
      phase_val_o <= 1'b0;
    end else begin
      sym_valid_o <= 1'b0;
      ctrl_sat_o  <= 1'b0;
      cfg_err_o   <= cfg_bad;
      phase_val_o <= (state_d != IDLE);
      if (cfg_ok) begin
        osf_q  <= osf_i;
        phi_q  <= '0;
        ctrl_q <= '0;
      end else begin
        phi_q       <= phi_nxt;
        sym_valid_o <= wrap;
        if (cap_en) begin
          ctrl_q     <= ctrl_clamp;
          ctrl_sat_o <= ctrl_clip;
        end
      end
    end
  end

  assign phase_int_o = phi_q[PHI_W-1:FRAC_W];
  assign mu_o        = phi_q[FRAC_W-1:0];

`ifdef SYM_NCO_SLIP_STATS_EN
  localparam int unsigned PER_W = INT_W + 2;

  logic [PER_W-1:0] per_cnt_q;
  logic             seen_q;
  logic [PER_W:0]   period;
  logic [PER_W:0]   osf_ext;

  assign period  = {1'b0, per_cnt_q} + (PER_W+1)'(1);
  assign osf_ext = (PER_W+1)'(osf_q);

  // Clocks between successive wrap edges; the first wrap after reset/load only arms the measurement
  always_ff @(posedge clk) begin
    if (!reset_n || cfg_ok) begin
      per_cnt_q   <= '0;
      seen_q      <= 1'b0;
      early_cnt_o <= '0;
      late_cnt_o  <= '0;
    end else if (wrap) begin
      per_cnt_q <= '0;
      seen_q    <= 1'b1;
      if (seen_q && (period < osf_ext) && (early_cnt_o != 16'hFFFF)) begin
        early_cnt_o <= early_cnt_o + 16'd1;
      end
      if (seen_q && (period > osf_ext) && (late_cnt_o != 16'hFFFF)) begin
        late_cnt_o <= late_cnt_o + 16'd1;
      end
    end else if (per_cnt_q != '1) begin
      per_cnt_q <= per_cnt_q + PER_W'(1);
    end
  end
`else
  assign early_cnt_o = 16'd0;
  assign late_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_sym_timing_nco.sv
// Scoreboard bench for sym_timing_nco: a sample-domain phase model predicts strobes, clamp and config-error pulses.
module tb_sym_timing_nco;
  localparam int INT_W  = 6;
  localparam int FRAC_W = 26;
  localparam int CTRL_W = 18;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [INT_W-1:0]  osf_i = '0;
  logic              cfg_load_i = 1'b0;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic              ctrl_valid_i = 1'b0;
  logic              hold_i = 1'b0;
  logic              sym_valid_o;
  logic [INT_W-1:0]  phase_int_o;
  logic [FRAC_W-1:0] mu_o;
  logic              phase_val_o;
  logic              ctrl_sat_o;
  logic              cfg_err_o;
  logic [15:0]       early_cnt_o;
  logic [15:0]       late_cnt_o;

  always #5 clk = ~clk;

  sym_timing_nco dut (
    .clk(clk), .reset_n(reset_n), .osf_i(osf_i), .cfg_load_i(cfg_load_i),
    .ctrl_i(ctrl_i), .ctrl_valid_i(ctrl_valid_i), .hold_i(hold_i),
    .sym_valid_o(sym_valid_o), .phase_int_o(phase_int_o), .mu_o(mu_o),
    .phase_val_o(phase_val_o), .ctrl_sat_o(ctrl_sat_o), .cfg_err_o(cfg_err_o),
    .early_cnt_o(early_cnt_o), .late_cnt_o(late_cnt_o)
  );

  typedef struct { int e; longint phi; bit pv; int early; int late; } strobe_t;
  strobe_t sq[$];
  int      satq[$];
  int      errq[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      mon_edge = 0;
  bit      cur_hold = 1'b0;

  // Reference model: phase in units of 2^-FRAC_W samples, periods measured as edge-index differences
  int     m_state;
  longint m_phi;
  int     m_osf, m_ctrl, m_early, m_late, m_last;
  bit     m_seen;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks = n_checks + 1;
    if (!ok) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: actual=%0d expected=%0d (edge %0d)", name, act, exp, mon_edge);
    end
  endtask

  function automatic longint m_step();
    longint s;
    s = longint'(1) << FRAC_W;
    if (m_state != 0) s = s + longint'(m_ctrl) * (longint'(1) << (FRAC_W - 12));
    return s;
  endfunction

  function automatic bit m_wraps_next();
    return (m_phi + m_step()) >= (longint'(m_osf) << FRAC_W);
  endfunction

  task automatic model_edge(input int e, input bit rn, input bit load, input int osf,
                            input int ctrl, input bit cv, input bit hold);
    longint  nphi;
    longint  thr;
    bit      wrapped;
    int      c;
    int      per;
    strobe_t s;
    if (!rn) begin
      m_state = 0; m_phi = 0; m_osf = 20; m_ctrl = 0;
      m_early = 0; m_late = 0; m_seen = 0; m_last = 0;
      return;
    end
    if (load && osf >= 2 && osf <= 32) begin
      m_osf = osf; m_phi = 0; m_ctrl = 0; m_state = 0;
      m_early = 0; m_late = 0; m_seen = 0;
      return;
    end
    if (load) errq.push_back(e);
    nphi = m_phi + m_step();
    thr  = longint'(m_osf) << FRAC_W;
    wrapped = (nphi >= thr);
    if (wrapped) nphi = nphi - thr;
    if (cv && m_state != 2) begin
      c = ctrl;
      if (c > 2047) c = 2047;
      else if (c < -2047) c = -2047;
      if (c != ctrl) satq.push_back(e);
      m_ctrl = c;
    end
    case (m_state)
      0: if (cv) m_state = 1;
      1: if (hold) m_state = 2;
      default: if (!hold) m_state = 1;
    endcase
    if (wrapped) begin
      if (m_seen) begin
        per = e - m_last;
        if (per < m_osf && m_early < 65535) m_early = m_early + 1;
        if (per > m_osf && m_late < 65535) m_late = m_late + 1;
      end
      m_seen = 1;
      m_last = e;
      s.e = e; s.phi = nphi; s.pv = (m_state != 0);
`ifdef SYM_NCO_SLIP_STATS_EN
      s.early = m_early; s.late = m_late;
`else
      s.early = 0; s.late = 0;
`endif
      sq.push_back(s);
    end
    m_phi = nphi;
  endtask

  task automatic drive(input bit rn, input bit load, input int osf, input int ctrl, input bit cv);
    @(negedge clk);
    reset_n = rn; cfg_load_i = load; osf_i = INT_W'(osf);
    ctrl_i = CTRL_W'(ctrl); ctrl_valid_i = cv; hold_i = cur_hold;
    model_edge(mon_edge + 1, rn, load, osf & 63, ctrl, cv, cur_hold);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents (or the model expects) an event
  initial begin
    strobe_t s;
    bit      exp_ev;
    forever begin
      @(posedge clk);
      mon_edge = mon_edge + 1;
      #1;
      exp_ev = (sq.size() > 0) && (sq[0].e == mon_edge);
      if (sym_valid_o || exp_ev) begin
        chk(sym_valid_o == exp_ev, "strobe_timing", longint'(sym_valid_o), longint'(exp_ev));
        if (exp_ev) begin
          s = sq.pop_front();
          if (sym_valid_o) begin
            chk({phase_int_o, mu_o} == s.phi, "strobe_phase", longint'({phase_int_o, mu_o}), s.phi);
            chk(phase_val_o == s.pv, "phase_val", longint'(phase_val_o), longint'(s.pv));
            chk(int'(early_cnt_o) == s.early, "early_cnt", longint'(early_cnt_o), longint'(s.early));
            chk(int'(late_cnt_o) == s.late, "late_cnt", longint'(late_cnt_o), longint'(s.late));
          end
        end
      end
      exp_ev = (satq.size() > 0) && (satq[0] == mon_edge);
      if (ctrl_sat_o || exp_ev) begin
        chk(ctrl_sat_o == exp_ev, "ctrl_sat", longint'(ctrl_sat_o), longint'(exp_ev));
        if (exp_ev) void'(satq.pop_front());
      end
      exp_ev = (errq.size() > 0) && (errq[0] == mon_edge);
      if (cfg_err_o || exp_ev) begin
        chk(cfg_err_o == exp_ev, "cfg_err", longint'(cfg_err_o), longint'(exp_ev));
        if (exp_ev) void'(errq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int r;
    int cval;
    // Reset state
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #2;
    chk(sym_valid_o == 1'b0, "rst_strobe", longint'(sym_valid_o), 0);
    chk({phase_int_o, mu_o} == '0, "rst_phase", longint'({phase_int_o, mu_o}), 0);
    chk(phase_val_o == 1'b0, "rst_phase_val", longint'(phase_val_o), 0);
    chk({early_cnt_o, late_cnt_o, ctrl_sat_o, cfg_err_o} == '0, "rst_flags",
        longint'({early_cnt_o, late_cnt_o, ctrl_sat_o, cfg_err_o}), 0);

    // Nominal cadence, then saturating positive and negative corrections
    drive(1'b1, 1'b1, 20, 0, 1'b0);
    run(70);
    drive(1'b1, 1'b0, 0, 2048, 1'b1);
    run(60);
    drive(1'b1, 1'b1, 20, 0, 1'b0);
    run(3);
    drive(1'b1, 1'b0, 0, -1024, 1'b1);
    run(90);
    @(posedge clk); #2;
    chk(phase_val_o == 1'b1, "track_phase_val", longint'(phase_val_o), 1);

    // Hold freezes the correction; release takes the next valid
    drive(1'b1, 1'b0, 0, 500, 1'b1);
    run(30);
    cur_hold = 1'b1;
    run(3);
    drive(1'b1, 1'b0, 0, 1000, 1'b1);
    run(40);
    cur_hold = 1'b0;
    run(1);
    drive(1'b1, 1'b0, 0, 1000, 1'b1);
    run(40);

    // Invalid and valid reconfiguration
    drive(1'b1, 1'b1, 1, 0, 1'b0);
    run(10);
    drive(1'b1, 1'b1, 33, 0, 1'b1);
    run(30);
    drive(1'b1, 1'b1, 8, 0, 1'b0);
    run(40);

    // Load coincident with a wrap edge
    drive(1'b1, 1'b0, 0, -300, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_wraps_next()) found = 1'b1;
      else run(1);
    end
    chk(found, "wrap_search", longint'(found), 1);
    drive(1'b1, 1'b1, 20, 0, 1'b1);
    @(posedge clk); #2;
    chk(sym_valid_o == 1'b0, "load_on_wrap_strobe", longint'(sym_valid_o), 0);
    chk({phase_int_o, mu_o} == '0, "load_on_wrap_phase", longint'({phase_int_o, mu_o}), 0);
    chk({early_cnt_o, late_cnt_o} == '0, "load_on_wrap_cnt", longint'({early_cnt_o, late_cnt_o}), 0);
    run(25);

    // Randomised traffic including mid-symbol resets
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) cur_hold = ~cur_hold;
      cval = int'($urandom_range(0, 6000)) - 3000;
      if (r < 2) drive(1'b0, 1'b1, int'($urandom_range(0, 63)), cval, 1'b1);
      else if (r < 6) drive(1'b1, 1'b1, int'($urandom_range(0, 40)), cval, $urandom_range(0, 1) == 1);
      else drive(1'b1, 1'b0, 0, cval, $urandom_range(0, 5) == 0);
    end
    cur_hold = 1'b0;
    run(40);

    @(posedge clk); #2;
    chk(sq.size() == 0, "strobe_queue_drained", longint'(sq.size()), 0);
    chk(satq.size() == 0, "sat_queue_drained", longint'(satq.size()), 0);
    chk(errq.size() == 0, "err_queue_drained", longint'(errq.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sym_timing_nco.md
SYM_TIMING_NCO -- requirements
Module: sym_timing_nco

Interface
REQ-001 The module SHALL have parameter OSF_MAX, default 32, meaning the largest runtime oversampling factor accepted.
REQ-002 The module SHALL have parameter INT_W, default 6, meaning the phase integer width, with 2^INT_W > OSF_MAX.
REQ-003 The module SHALL have parameter FRAC_W, default 26, meaning the phase fraction width, with FRAC_W >= 12.
REQ-004 The module SHALL have parameter CTRL_W, default 18, meaning the signed control width, with LSB weight 2^-12 sample.
REQ-005 The module SHALL have parameter MAX_CORR, default 2047, meaning the control magnitude limit in LSBs, which must be < 4096.
REQ-006 The module SHALL have port clk, input, 1 bit, the clock.
REQ-007 The module SHALL have port reset_n, input, 1 bit, a synchronous active-low reset.
REQ-008 The module SHALL have port osf_i, input, INT_W bits, the requested samples per symbol.
REQ-009 The module SHALL have port cfg_load_i, input, 1 bit, which applies osf_i.
REQ-010 The module SHALL have port ctrl_i, input, CTRL_W bits, the signed timing correction.
REQ-011 The module SHALL have port ctrl_valid_i, input, 1 bit, which qualifies ctrl_i.
REQ-012 The module SHALL have port hold_i, input, 1 bit, which freezes the correction.
REQ-013 The module SHALL have port sym_valid_o, output, 1 bit, a one-cycle symbol strobe.
REQ-014 The module SHALL have port phase_int_o, output, INT_W bits, the phase integer part.
REQ-015 The module SHALL have port mu_o, output, FRAC_W bits, the phase fraction (Q0.FRAC_W).
REQ-016 The module SHALL have port phase_val_o, output, 1 bit, which is high while in TRACK or HOLD.
REQ-017 The module SHALL have port ctrl_sat_o, output, 1 bit, a one-cycle pulse indicating ctrl_i was clamped.
REQ-018 The module SHALL have port cfg_err_o, output, 1 bit, a one-cycle pulse indicating osf_i was rejected.
REQ-019 The module SHALL have port early_cnt_o, output, 16 bits, the count of short symbol periods.
REQ-020 The module SHALL have port late_cnt_o, output, 16 bits, the count of long symbol periods.

Function
REQ-021 The module SHALL implement states IDLE, TRACK and HOLD; reset and every accepted cfg_load_i SHALL enter IDLE.
REQ-022 The module SHALL move from IDLE to TRACK on the first ctrl_valid_i; from TRACK to HOLD when hold_i=1; and from HOLD to TRACK when hold_i=0.
REQ-023 The module SHALL register ctrl_q, clamped to ±MAX_CORR, on each ctrl_valid_i in IDLE or TRACK; ctrl_valid_i SHALL be ignored in HOLD.
REQ-024 The module SHALL pulse ctrl_sat_o one cycle after each clamped capture.
REQ-025 The module SHALL use, in IDLE, step = 1<<FRAC_W; in TRACK and HOLD, step = (1<<FRAC_W) + sign-extended ctrl_q << (FRAC_W-12).
REQ-026 The module SHALL apply a ctrl_i value captured at edge N to the phase update at edge N+1.
REQ-027 The module SHALL compute phi_next = phi + step every clock, at full width without overflow.
REQ-028 The module SHALL, when phi_next >= osf_q<<FRAC_W, store phi = phi_next - (osf_q<<FRAC_W) and assert sym_valid_o in the following cycle, aligned with the wrapped phi.
REQ-029 The module SHALL ensure at most one wrap per clock, since |correction| < 1 sample.
REQ-030 The module SHALL drive phase_int_o = phi[INT_W+FRAC_W-1:FRAC_W] and mu_o = phi[FRAC_W-1:0].
REQ-031 The module SHALL accept cfg_load_i only when 2 <= osf_i <= OSF_MAX, setting osf_q, phi=0 and ctrl_q=0.
REQ-032 The module SHALL, when cfg_load_i carries an invalid osf_i, keep osf_q, state and phi unchanged and pulse cfg_err_o one cycle later.
REQ-033 The module SHALL give cfg_load_i priority over a simultaneous ctrl_valid_i and wrap; no strobe SHALL be emitted on that edge.

Reset
REQ-034 The module SHALL, on reset_n=0 at a clock edge, set phi=0, ctrl_q=0, osf_q=min(20, OSF_MAX), state=IDLE, and all outputs and counters to 0.
REQ-035 The module SHALL treat a reset asserted mid-symbol as overriding all other inputs in that cycle.

Configuration
REQ-036 The module SHALL, with SYM_NCO_SLIP_STATS_EN defined, count clocks between successive strobes, incrementing early_cnt_o when the period < osf_q and late_cnt_o when the period > osf_q.
REQ-037 The slip counters SHALL saturate at 0xFFFF and be cleared by an accepted cfg_load_i.
REQ-038 The first strobe after reset or load SHALL not be counted.
REQ-039 The module SHALL, without SYM_NCO_SLIP_STATS_EN, tie early_cnt_o and late_cnt_o to 0 and include no counter logic.

Verification
REQ-040 Reset, then osf_i=20 with cfg_load_i, no ctrl -> sym_valid_o exactly every 20 clocks, mu_o=0, phase_val_o=0.
REQ-041 ctrl_i=+2048 with ctrl_valid_i -> ctrl_sat_o pulses, ctrl_q=2047, symbol periods 13/14 clocks, early_cnt_o increments per strobe (with macro).
REQ-042 ctrl_i=-1024 (-0.25 sample), osf_i=20 -> periods of 26/27 clocks, phase_val_o=1, late_cnt_o increments.
REQ-043 In TRACK, hold_i=1, then ctrl_i=+1000 valid -> step unchanged; hold_i=0, new valid -> applied on the next edge.
REQ-044 cfg_load_i with osf_i=1 or 33 -> cfg_err_o pulse, strobe cadence unchanged; osf_i=8 -> phi=0, IDLE, strobe every 8 clocks.
REQ-045 cfg_load_i coincident with a wrap edge -> no strobe, phi=0, counters cleared.
